// File: rtl/round_robin_timer_pkg.sv
// Shared types and default constants for the round-robin quantum timer.
// Optional feature macro used elsewhere in this slice: RR_BLOCK_RESTART_EN.
package rr_timer_pkg;

    localparam int PID_W_DEF      = 5;
    localparam int QUANTUM_DEF    = 100;
    localparam int KERNEL_PID_DEF = 0;

    // Scheduler-facing state of the time slice
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

endpackage

// File: rtl/round_robin_timer_if.sv
// Scheduler <-> timer signal bundle.
// The scheduler (master) drives Atv_Temp/Block/PID_in every cycle; the timer
// (slave) returns the registered effective PID. There is no valid/ready pair:
// every input is sampled on each rising clock edge and PID_out is valid at all
// times after reset.
interface round_robin_timer_if #(
    parameter int PID_W = rr_timer_pkg::PID_W_DEF
);
    logic             Atv_Temp;
    logic             Block;
    logic [PID_W-1:0] PID_in;
    logic [PID_W-1:0] PID_out;

    modport master (
        output Atv_Temp,
        output Block,
        output PID_in,
        input  PID_out
    );

    modport slave (
        input  Atv_Temp,
        input  Block,
        input  PID_in,
        output PID_out
    );
endinterface

// File: rtl/round_robin_timer_quantum_counter.sv
// Time-slice counter: counts enabled, non-held cycles from 0 to QUANTUM-1,
// pulses tc on the cycle that completes the slice and wraps back to 0.
// clear has priority over hold and enable.
module rr_quantum_counter #(
    parameter  int QUANTUM = rr_timer_pkg::QUANTUM_DEF,
    localparam int CW      = $clog2(QUANTUM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    input  logic          hold,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(QUANTUM - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count and terminal-count pulse
    always_comb begin
        count_d = count_q;
        tc      = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable && !hold) begin
            if (count_q == LAST) begin
                count_d = '0;
                tc      = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/round_robin_timer.sv
// Round-robin quantum timer: arms on Atv_Temp, counts the slice while the
// process is not blocked, and forces KERNEL_PID on expiry until re-armed.
// Optional build macro: RR_BLOCK_RESTART_EN -- when defined, Block in RUN
// clears the slice count so an I/O wait earns a fresh full quantum.
module round_robin_timer
    import rr_timer_pkg::*;
#(
    parameter  int PID_W      = PID_W_DEF,
    parameter  int QUANTUM    = QUANTUM_DEF,
    parameter  int KERNEL_PID = KERNEL_PID_DEF,
    localparam int CW         = $clog2(QUANTUM)
) (
    input  logic                  clk,
    input  logic                  reset,
    round_robin_timer_if.slave    bus,
    output state_t                state_o,
    output logic [CW-1:0]         count_o
);

    localparam logic [PID_W-1:0] KPID = PID_W'(KERNEL_PID);

    state_t           state_q;
    state_t           state_d;
    logic [PID_W-1:0] pid_out_q;
    logic [PID_W-1:0] pid_out_d;

    logic          in_run;
    logic          cnt_clear;
    logic          cnt_tc;
    logic [CW-1:0] cnt_value;

    assign in_run = (state_q == RUN);

`ifdef RR_BLOCK_RESTART_EN
    assign cnt_clear = bus.Atv_Temp | (in_run & bus.Block);
`else
    assign cnt_clear = bus.Atv_Temp;
`endif

    rr_quantum_counter #(
        .QUANTUM (QUANTUM)
    ) u_counter (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (cnt_clear),
        .enable (in_run),
        .hold   (bus.Block),
        .count  (cnt_value),
        .tc     (cnt_tc)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: arming wins everywhere; expiry only from an unblocked RUN
    always_comb begin
        state_d = state_q;
        if (bus.Atv_Temp) begin
            state_d = RUN;
        end else if (in_run && cnt_tc) begin
            state_d = EXPIRED;
        end
    end

    // Output decode: PID follows the state being entered, so expiry is visible right after the expiring edge
    always_comb begin
        pid_out_d = bus.PID_in;
        if (state_d == EXPIRED) begin
            pid_out_d = KPID;
        end
    end

    // Effective PID register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pid_out_q <= KPID;
        end else begin
            pid_out_q <= pid_out_d;
        end
    end

    assign bus.PID_out = pid_out_q;
    assign state_o     = state_q;
    assign count_o     = cnt_value;

endmodule

// File: tb/tb_round_robin_timer.sv
// Bench for round_robin_timer with QUANTUM=4, PID_W=5, KERNEL_PID=0.
module tb_round_robin_timer;
    import rr_timer_pkg::*;

    localparam int PID_W = 5;
    localparam int QUANTUM = 4;
    localparam int CW = $clog2(QUANTUM);
    localparam int EW = 2 + CW + PID_W;

    typedef struct {
        logic             atv;
        logic             blk;
        logic [PID_W-1:0] pid;
        logic [EW-1:0]    exp;
    } vec_t;

    logic          clk;
    logic          reset;
    state_t        state_o;
    logic [CW-1:0] count_o;

    logic [EW-1:0] exp_q[$];
    int n_vec;
    int n_err;

    vec_t vecs[35];

    round_robin_timer_if #(.PID_W(PID_W)) bus ();

    round_robin_timer #(
        .PID_W      (PID_W),
        .QUANTUM    (QUANTUM),
        .KERNEL_PID (0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (state_o),
        .count_o (count_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout, required finish");
        $fatal(1);
    end

    function automatic logic [EW-1:0] pack(state_t st, int cnt, int pid);
        logic [1:0]       s;
        logic [CW-1:0]    c;
        logic [PID_W-1:0] p;
        s = st;
        c = CW'(cnt);
        p = PID_W'(pid);
        return {s, c, p};
    endfunction

    function automatic vec_t mk(logic atv, logic blk, int pid,
                                int exp_pid, state_t st, int cnt);
        vec_t v;
        v.atv = atv;
        v.blk = blk;
        v.pid = PID_W'(pid);
        v.exp = pack(st, cnt, exp_pid);
        return v;
    endfunction

    // scoreboard: compare DUT outputs with the oldest expectation
    task automatic check(input string name);
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        logic [1:0]    s;
        s   = state_o;
        got = {s, count_o, bus.PID_out};
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got output with no expectation queued", name);
            return;
        end
        exp = exp_q.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got state=%0d count=%0d pid=%0d, required state=%0d count=%0d pid=%0d",
                     name, got[EW-1 -: 2], got[PID_W +: CW], got[PID_W-1:0],
                     exp[EW-1 -: 2], exp[PID_W +: CW], exp[PID_W-1:0]);
        end
    endtask

    // driver: apply inputs at negedge, sample #1 after the rising edge
    task automatic apply(input logic atv, input logic blk, input logic [PID_W-1:0] pid,
                         input logic [EW-1:0] exp, input string name);
        @(negedge clk);
        bus.Atv_Temp = atv;
        bus.Block    = blk;
        bus.PID_in   = pid;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check(name);
    endtask

    initial begin
        state_t           m_st;
        int               m_cnt;
        logic             atv;
        logic             blk;
        logic [PID_W-1:0] pid;

        n_vec = 0;
        n_err = 0;

        // idle / block-ignored
        vecs[0]  = mk(0, 0, 7,  7, IDLE, 0);
        vecs[1]  = mk(0, 0, 7,  7, IDLE, 0);
        vecs[2]  = mk(0, 1, 7,  7, IDLE, 0);
        // plain slice, expiry at edge 4, sticky, block ignored in EXPIRED
        vecs[3]  = mk(1, 0, 5,  5, RUN, 0);
        vecs[4]  = mk(0, 0, 5,  5, RUN, 1);
        vecs[5]  = mk(0, 0, 5,  5, RUN, 2);
        vecs[6]  = mk(0, 0, 5,  5, RUN, 3);
        vecs[7]  = mk(0, 0, 5,  0, EXPIRED, 0);
        vecs[8]  = mk(0, 0, 5,  0, EXPIRED, 0);
        vecs[9]  = mk(0, 1, 5,  0, EXPIRED, 0);
        // block on edges 1-2, expiry at edge 6
        vecs[10] = mk(1, 0, 5,  5, RUN, 0);
        vecs[11] = mk(0, 1, 5,  5, RUN, 0);
        vecs[12] = mk(0, 1, 5,  5, RUN, 0);
        vecs[13] = mk(0, 0, 5,  5, RUN, 1);
        vecs[14] = mk(0, 0, 5,  5, RUN, 2);
        vecs[15] = mk(0, 0, 5,  5, RUN, 3);
        vecs[16] = mk(0, 0, 5,  0, EXPIRED, 0);
        // re-arm at edge 2, expiry at edge 6
        vecs[17] = mk(1, 0, 3,  3, RUN, 0);
        vecs[18] = mk(0, 0, 3,  3, RUN, 1);
        vecs[19] = mk(1, 0, 3,  3, RUN, 0);
        vecs[20] = mk(0, 0, 3,  3, RUN, 1);
        vecs[21] = mk(0, 0, 3,  3, RUN, 2);
        vecs[22] = mk(0, 0, 3,  3, RUN, 3);
        vecs[23] = mk(0, 0, 3,  0, EXPIRED, 0);
        // arm from EXPIRED with new PID
        vecs[24] = mk(1, 0, 9,  9, RUN, 0);
        vecs[25] = mk(0, 0, 9,  9, RUN, 1);
        vecs[26] = mk(0, 0, 9,  9, RUN, 2);
        vecs[27] = mk(0, 0, 9,  9, RUN, 3);
        vecs[28] = mk(0, 0, 9,  0, EXPIRED, 0);
        // arm while blocked; PID_out tracks PID_in changes in RUN
        vecs[29] = mk(1, 1, 11, 11, RUN, 0);
        vecs[30] = mk(0, 1, 11, 11, RUN, 0);
        vecs[31] = mk(0, 0, 12, 12, RUN, 1);
        vecs[32] = mk(0, 0, 12, 12, RUN, 2);
        vecs[33] = mk(0, 0, 12, 12, RUN, 3);
        vecs[34] = mk(0, 0, 12, 0, EXPIRED, 0);

        // reset held with PID_in=7
        reset        = 1'b0;
        bus.Atv_Temp = 1'b0;
        bus.Block    = 1'b0;
        bus.PID_in   = 5'd7;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(pack(IDLE, 0, 0));
        check("reset_state");
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].atv, vecs[i].blk, vecs[i].pid, vecs[i].exp,
                  $sformatf("vec%0d", i));
        end

        // asynchronous reset in the middle of a slice
        apply(1, 0, 6, pack(RUN, 0, 6), "mid_arm");
        apply(0, 0, 6, pack(RUN, 1, 6), "mid_e1");
        apply(0, 0, 6, pack(RUN, 2, 6), "mid_e2");
        @(negedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back(pack(IDLE, 0, 0));
        #1;
        check("async_reset");
        @(negedge clk);
        reset = 1'b1;
        apply(0, 0, 6, pack(IDLE, 0, 6), "after_reset");

        // random traffic against a behavioural model of the slice rules
        m_st  = IDLE;
        m_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            atv = ($urandom_range(0, 7) == 0);
            blk = ($urandom_range(0, 3) == 0);
            pid = PID_W'($urandom_range(0, 31));
            if (atv) begin
                m_st  = RUN;
                m_cnt = 0;
            end else if (m_st == RUN && blk) begin
`ifdef RR_BLOCK_RESTART_EN
                m_cnt = 0;
`endif
            end else if (m_st == RUN && m_cnt == QUANTUM - 1) begin
                m_st  = EXPIRED;
                m_cnt = 0;
            end else if (m_st == RUN) begin
                m_cnt = m_cnt + 1;
            end
            apply(atv, blk, pid,
                  pack(m_st, m_cnt, (m_st == EXPIRED) ? 0 : int'(pid)),
                  $sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
